// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader and its word assembler.
package program_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    // Default largest program length in 32-bit words
    localparam int DEFAULT_MAX_WORDS = 64;

    // Byte-counter value of the last byte of a word (words are 4 bytes)
    localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

    // Running stream checksum: XOR of all data bytes
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects bytes MSB first into a 32-bit word and flags the 4th byte of each word.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_complete
);

    logic [31:0] r_word;
    logic [1:0]  r_count;

    // Shift register and 0..3 byte counter; the counter wraps after each word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word  <= 32'h0000_0000;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_word  <= 32'h0000_0000;
            r_count <= 2'd0;
        end else if (i_shift) begin
            r_word  <= {r_word[23:0], i_byte};
            r_count <= r_count + 2'd1;
        end
    end

    assign o_word          = r_word;
    assign o_word_complete = i_shift && (r_count == LAST_BYTE_IDX);

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed, checksummed byte stream,
// writes the words into instruction memory and releases the CPU when the load is good.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_e             r_state;
    state_e             w_next;
    logic [15:0]        r_len;
    logic [IDX_W-1:0]   r_index;
    logic [7:0]         r_acc;
    logic               r_rx_ready;
    logic               r_imem_we;
    logic [31:0]        r_imem_addr;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_error;

    logic               w_xfer;
    logic               w_shift;
    logic               w_word_complete;
    logic [31:0]        w_word;
    logic               w_reload_ok;
    logic [15:0]        w_len_full;
    logic               w_len_ok;
    logic               w_last_word;

    assign w_xfer      = rx_valid && r_rx_ready;
    assign w_shift     = w_xfer && (r_state == ST_DATA);
    assign w_reload_ok = reload && ((r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len_full  = {r_len[15:8], rx_byte};
    assign w_len_ok    = (w_len_full != 16'd0) && (w_len_full <= 16'(MAX_WORDS));
    assign w_last_word = ((16'(r_index) + 16'd1) == r_len);

    word_assembler u_word_assembler (
        .clock           (clock),
        .reset           (reset),
        .i_clear         (w_reload_ok),
        .i_shift         (w_shift),
        .i_byte          (rx_byte),
        .o_word          (w_word),
        .o_word_complete (w_word_complete)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_LEN_HI;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LEN_HI: begin
                if (w_xfer) w_next = ST_LEN_LO;
                else        w_next = r_state;
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_ok) w_next = ST_DATA;
                    else          w_next = ST_ERR;
                end else begin
                    w_next = r_state;
                end
            end
            ST_DATA: begin
                if (w_word_complete) w_next = ST_WRITE;
                else                 w_next = r_state;
            end
            ST_WRITE: begin
                if (w_last_word) w_next = ST_CHECK;
                else             w_next = ST_DATA;
            end
            ST_CHECK: begin
                if (w_xfer) begin
                    if (rx_byte == r_acc) w_next = ST_DONE;
                    else                  w_next = ST_ERR;
                end else begin
                    w_next = r_state;
                end
            end
            ST_DONE, ST_ERR: begin
                if (reload) w_next = ST_LEN_HI;
                else        w_next = r_state;
            end
            default: w_next = ST_ERR;
        endcase
    end

    // Length capture, word index and checksum accumulator
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len   <= 16'd0;
            r_index <= '0;
            r_acc   <= 8'h00;
        end else begin
            case (r_state)
                ST_LEN_HI: if (w_xfer) r_len <= {rx_byte, 8'h00};
                ST_LEN_LO: if (w_xfer) r_len <= w_len_full;
                ST_DATA:   if (w_xfer) r_acc <= csum_update(r_acc, rx_byte);
                ST_WRITE:  r_index <= r_index + IDX_W'(1);
                ST_DONE, ST_ERR: begin
                    if (reload) begin
                        r_index <= '0;
                        r_acc   <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs registered from the next state so they change cleanly with the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_ready  <= 1'b1;
            r_imem_we   <= 1'b0;
            r_imem_addr <= 32'h0000_0000;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rx_ready  <= (w_next inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK});
            r_imem_we   <= (w_next == ST_WRITE);
            r_imem_addr <= BASE_ADDR + (32'(r_index) << 2);
            r_cpu_hold  <= (w_next != ST_DONE);
            r_done      <= (w_next == ST_DONE);
            r_error     <= (w_next == ST_ERR);
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = w_word;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64: largest accepted program length in words.
REQ-002 Parameter BASE_ADDR, default 32'h0: instruction-memory byte address of word 0.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 rx_valid  input  1  byte on rx_byte is valid.
REQ-006 rx_byte  input  8  incoming stream byte.
REQ-007 rx_ready  output  1  loader accepts the byte; transfer occurs when rx_valid && rx_ready at the clock edge.
REQ-008 reload  input  1  one-cycle request to restart loading; honoured only in DONE or ERR.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  32  instruction-memory byte address (word aligned).
REQ-011 imem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the processor PC/register in reset while high.
REQ-013 done  output  1  program loaded and checksum good.
REQ-014 error  output  1  load aborted (bad length or checksum).

Function
REQ-015 The loader SHALL run the stream format: LEN_HI byte, LEN_LO byte (16-bit word count N, MSB first), then 4*N data bytes (each word MSB first), then one checksum byte equal to the XOR of all 4*N data bytes.
REQ-016 The FSM SHALL have the states LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR.
REQ-017 LEN_HI->LEN_LO on transfer; LEN_LO->DATA on transfer when 1<=N<=MAX_WORDS, else ->ERR.
REQ-018 DATA: each transfer SHALL shift the byte into a 32-bit assembly register and XOR it into the checksum accumulator; the 4th byte SHALL move the FSM to WRITE.
REQ-019 WRITE lasts exactly one cycle: imem_we=1, imem_addr=BASE_ADDR+4*index, imem_wdata=assembled word, rx_ready=0; then index+1; ->CHECK if index+1==N, else ->DATA.
REQ-020 CHECK: on transfer ->DONE if the byte equals the accumulator, else ->ERR.
REQ-021 rx_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA, CHECK.
REQ-022 imem_we SHALL be 0 outside WRITE; imem_addr/imem_wdata are don't-care when imem_we=0.
REQ-023 cpu_hold SHALL be 1 in every state except DONE; done=1 only in DONE; error=1 only in ERR.
REQ-024 DONE and ERR SHALL ignore rx_valid (rx_ready=0); reload in either state SHALL clear index, byte counter and accumulator and go to LEN_HI. reload in any other state SHALL be ignored.
REQ-025 Gaps (rx_valid low) in any receiving state SHALL stall without state change; no timeout.
REQ-026 Word index and byte counter SHALL be sized for MAX_WORDS; index never exceeds N.
REQ-027 Words beyond N SHALL never be written; memory contents from earlier loads are left untouched.

Reset
REQ-028 Reset SHALL force state LEN_HI, index 0, byte counter 0, accumulator 0, assembly register 0, N 0.
REQ-029 Reset outputs: rx_ready=1 after release, imem_we=0, cpu_hold=1, done=0, error=0; reset mid-load SHALL abandon the load immediately with no further imem_we.

Structure
REQ-030 A shared package SHALL hold the state enum type and the default MAX_WORDS constant.
REQ-031 One sub-module, word_assembler (byte shift register plus 0..3 byte counter plus word_complete flag), SHALL be used; FSM, index and checksum stay in program_loader.

Verification
REQ-032 Stream 00 01 12 34 56 78 08 -> one imem_we with addr 0x0, wdata 0x12345678; then done=1, cpu_hold=0.
REQ-033 N=3 words 0x20080005, 0x21090001, 0xAC090000 with correct XOR checksum, rx_valid toggled every other cycle -> writes at 0x0, 0x4, 0x8 in order, then DONE.
REQ-034 Length 00 00, and separately 00 41 (65 > MAX_WORDS) -> ERR after LEN_LO, no imem_we, cpu_hold stays 1.
REQ-035 Valid one-word stream with checksum 0x09 instead of 0x08 -> write occurs, then error=1, done=0, cpu_hold=1.
REQ-036 Reset asserted after 2 data bytes of word 0 -> no imem_we, outputs at reset values; a following complete stream loads correctly.
REQ-037 reload pulse in DONE, then new one-word stream 00 01 DE AD BE EF 22 -> write 0xDEADBEEF at 0x0, done=1; reload pulse during DATA -> no effect.
